md_unit: RTL and testbench

Multiply/divide unit for the E stage of the pipelined MIPS core. It consumes the mult/div/mthi/mtlo class of operations identified by instruction decode, executes each multi-cycle operation on a countdown, and holds the architectural HI/LO registers. It exports `start` and `busy` so the hazard unit can stall dependent md instructions. It accepts a kill input so precise exceptions never commit a partially executed operation.

---
 rtl/md_unit.sv | 177 +++++++++++++++++
 tb/tb_md_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the E stage of the pipelined MIPS core.
//
// Executes mult/multu/div/divu on a countdown and owns the architectural HI/LO
// registers. The 64-bit result is computed at the accepting edge and held in
// shadow registers. It is copied to HI/LO when the countdown expires, so a kill
// or reset before that point leaves HI/LO untouched.
//
// Parameters:
//   MULT_CYCLES  busy duration of mult/multu (1..15)
//   DIV_CYCLES   busy duration of div/divu   (1..15)
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset_n  in   1  asynchronous active-low reset
//   md_op    in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//                    (7 = none)
//   a, b     in  32  forwarded rs / rt operands
//   kill     in   1  exception taken: blocks acceptance, aborts in-flight op
//   start    out  1  combinational, a mult/div is accepted this cycle
//   busy     out  1  registered, an operation is in flight
//   hi, lo   out 32  architectural HI / LO
//
// Configuration macro:
//   MD_FAST_MULT_EN  when defined, mult/multu commit HI/LO at the accepting
//                    edge and never raise busy. div/divu are unaffected.
// -----------------------------------------------------------------------------
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_op_e op;
  assign op = md_op_e'(md_op);

  // State
  logic [3:0]  count_q, count_d;
  logic        busy_q,  busy_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [31:0] hi_s_q,  hi_s_d;
  logic [31:0] lo_s_q,  lo_s_d;
  logic        dz_q,    dz_d;     // in-flight divide has a zero divisor

  // Operation class decode
  logic is_mul, is_div, is_signed;
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  assign start = (is_mul || is_div) && !busy_q && !kill;

  // Multiply: operands are sign- or zero-extended to 64 bits. The low 64 bits
  // of the 64x64 product are then the exact 32x32 result in either mode.
  logic [63:0] a_ext, b_ext, product;
  assign a_ext   = {{32{is_signed & a[31]}}, a};
  assign b_ext   = {{32{is_signed & b[31]}}, b};
  assign product = a_ext * b_ext;

  // Divide: a magnitude divider with sign fix-up. The quotient truncates
  // toward zero and the remainder follows the dividend. For 0x80000000 / -1
  // the magnitude 0x80000000 survives negation, which gives LO=0x80000000, HI=0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;
  assign a_neg   = is_signed & a[31];
  assign b_neg   = is_signed & b[31];
  assign a_mag   = a_neg ? (32'd0 - a) : a;
  assign b_mag   = b_neg ? (32'd0 - b) : b;
  // A zero divisor never commits, so the divider is fed 1 to keep it defined.
  assign div_den = (b == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / div_den;
  assign r_mag   = a_mag % div_den;
  assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned. Without the defaults, latches would be inferred.
  always_comb begin
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_s_d  = hi_s_q;
    lo_s_d  = lo_s_q;
    dz_d    = dz_q;

    if (kill) begin
      // Abort: drop the countdown and commit nothing. The shadows are dead.
      count_d = 4'd0;
    end else if (busy_q) begin
      // Requests arriving while busy are ignored. Upstream stalls them.
      count_d = count_q - 4'd1;
      if (count_q == 4'd1 && !dz_q) begin
        hi_d = hi_s_q;
        lo_d = lo_s_q;
      end
    end else begin
      unique case (op)
        OP_MULT, OP_MULTU: begin
`ifdef MD_FAST_MULT_EN
          hi_d    = product[63:32];
          lo_d    = product[31:0];
`else
          hi_s_d  = product[63:32];
          lo_s_d  = product[31:0];
          dz_d    = 1'b0;
          count_d = MULT_CNT;
`endif
        end
        OP_DIV, OP_DIVU: begin
          hi_s_d  = rem;
          lo_s_d  = quot;
          dz_d    = (b == 32'd0);
          count_d = DIV_CNT;
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  assign busy_d = (count_d != 4'd0);

  // NOTE: sequential state uses non-blocking assignments only. Each register
  // then samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      // NOTE: the shadow registers are reset as well. They are never visible
      // unless they commit, but clearing them keeps post-reset state fully
      // defined.
      hi_s_q  <= 32'd0;
      lo_s_q  <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_s_q  <= hi_s_d;
      lo_s_q  <= lo_s_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit.
// The stimulus thread issues operations and pushes the expected HI/LO and busy
// length of each multi-cycle op into a queue. A monitor counts busy cycles at
// every falling edge. When busy drops, it pops the queue and compares.
// Single-cycle effects (start, mthi/mtlo, kill, reset) are checked in-line.
// -----------------------------------------------------------------------------
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        kill;
  logic        start, busy;
  logic [31:0] hi, lo;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .md_op(md_op), .a(a), .b(b), .kill(kill),
    .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: measure each busy run and check the result it leaves behind.
  int run = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0;
    end else if (busy) begin
      run++;
    end else if (run > 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_run", 64'(run), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_busy_len"}, 64'(run), 64'(e.cycles));
        check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
        check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      end
      run = 0;
    end
  end

  // Drive one op just after a falling edge, check start, then return at the
  // next falling edge (cycle T0+1) with the inputs returned to idle.
  task automatic issue(input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic kv,
                       input logic exp_start, input string name);
    md_op = op; a = av; b = bv; kill = kv;
    #1;
    check({name, "_start"}, {63'd0, start}, {63'd0, exp_start});
    @(negedge clk);
    md_op = 3'd0; kill = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic push(input string name, input logic [31:0] h,
                      input logic [31:0] l, input int cyc);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.cycles = cyc;
    exp_q.push_back(e);
  endtask

  task automatic do_mult(input logic [2:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] h,
                         input logic [31:0] l, input string name);
    issue(op, av, bv, 1'b0, 1'b1, name);
`ifdef MD_FAST_MULT_EN
    check({name, "_fast_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_fast_hi"}, {32'd0, hi}, {32'd0, h});
    check({name, "_fast_lo"}, {32'd0, lo}, {32'd0, l});
`else
    push(name, h, l, MULT_N);
    wait_idle(name);
`endif
  endtask

  task automatic do_div(input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] h,
                        input logic [31:0] l, input string name);
    issue(op, av, bv, 1'b0, 1'b1, name);
    push(name, h, l, DIV_N);
    wait_idle(name);
  endtask

  initial begin
    reset_n = 1'b0; md_op = 3'd0; a = '0; b = '0; kill = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("idle_start", {63'd0, start}, 64'd0);

    // Arithmetic
    do_mult(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
    do_mult(3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    do_div(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
    do_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");

    // mthi/mtlo preset, then divide by zero leaves them alone
    issue(3'd5, 32'h11, 32'd0, 1'b0, 1'b0, "mthi");
    check("mthi_hi", {32'd0, hi}, 64'h11);
    issue(3'd6, 32'h22, 32'd0, 1'b0, 1'b0, "mtlo");
    check("mtlo_lo", {32'd0, lo}, 64'h22);
    do_div(3'd4, 32'd100, 32'd0, 32'h11, 32'h22, "divu_by0");
    do_div(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");

    // Kill in cycle 3 of a multi-cycle op: busy falls in cycle 4, no commit
`ifdef MD_FAST_MULT_EN
    issue(3'd4, 32'd25, 32'd1, 1'b0, 1'b1, "kill_mid");
`else
    issue(3'd1, 32'd5, 32'd5, 1'b0, 1'b1, "kill_mid");
`endif
    push("kill_mid", 32'd2, 32'd14, 3);
    @(negedge clk);                 // cycle 2
    @(negedge clk); kill = 1'b1;    // cycle 3
    @(negedge clk); kill = 1'b0;    // cycle 4
    check("kill_mid_busy", {63'd0, busy}, 64'd0);

    // Kill on the final busy cycle still blocks the commit
    issue(3'd4, 32'd9, 32'd2, 1'b0, 1'b1, "kill_last");
    push("kill_last", 32'd2, 32'd14, DIV_N);
    repeat (DIV_N - 1) @(negedge clk);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    check("kill_last_busy", {63'd0, busy}, 64'd0);

    // Kill alongside mthi and alongside a mult request: nothing happens
    issue(3'd5, 32'hDEAD, 32'd0, 1'b1, 1'b0, "kill_mthi");
    check("kill_mthi_hi", {32'd0, hi}, 64'd2);
    issue(3'd1, 32'd3, 32'd3, 1'b1, 1'b0, "kill_t0");
    check("kill_t0_busy", {63'd0, busy}, 64'd0);
    check("kill_t0_lo", {32'd0, lo}, 64'd14);

    issue(3'd6, 32'h1234, 32'd0, 1'b0, 1'b0, "mtlo_idle");
    check("mtlo_idle_lo", {32'd0, lo}, 64'h1234);

    // While busy: divu and mthi are ignored, and the in-flight op commits
    issue(3'd4, 32'd84, 32'd2, 1'b0, 1'b1, "busy_divu");
    push("busy_divu", 32'd0, 32'd42, DIV_N);
    issue(3'd4, 32'd1, 32'd1, 1'b0, 1'b0, "busy_req_divu");
    issue(3'd5, 32'hBAD, 32'd0, 1'b0, 1'b0, "busy_req_mthi");
    check("busy_mthi_hi", {32'd0, hi}, 64'd2);
    wait_idle("busy_divu");

    // Back-to-back: the next op is accepted in the cycle busy falls
    do_mult(3'd1, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "b2b_mult");

`ifdef MD_FAST_MULT_EN
    issue(3'd6, 32'd0, 32'd0, 1'b0, 1'b0, "clr_lo");
    do_mult(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, "fast_mult");
`endif

    // Asynchronous reset in the middle of a divide
    issue(3'd4, 32'd100, 32'd7, 1'b0, 1'b1, "rst_div");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (DIV_N + 2) @(negedge clk);
    check("rst_mid_no_commit", {32'd0, lo}, 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
